// File: rtl/ordering_host_seq.sv
// Host-side sequencer for the replica ordering register port: write beats pass straight
// through; read beats are issued under a credit limit and returned through a skid FIFO.
module ordering_host_seq #(
   parameter int CITY_DIV_LOG = 5,
   parameter int NODE_NUM     = 32,
   parameter int NODE_LOG     = 5,
   parameter int RD_LAT       = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [CITY_DIV_LOG-1:0] cmd_words,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   input  logic [63:0]             s_wdata,
   output logic                    m_rvalid,
   input  logic                    m_rready,
   output logic [63:0]             m_rdata,
   output logic                    m_rlast,
   output logic [CITY_DIV_LOG-1:0] ordering_num,
   output logic                    ordering_write,
   output logic [63:0]             ordering_wdata,
   output logic                    ordering_read,
   input  logic [63:0]             ordering_rdata,
   input  logic                    ordering_ready,
   input  logic                    exchange_shift_n,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [NODE_LOG-1:0] NODE_LAST = NODE_LOG'(NODE_NUM - 1);
   localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [2:0] {IDLE, WR, RD, RD_DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [CITY_DIV_LOG-1:0] word_cnt;
   logic [NODE_LOG-1:0]     node_cnt;
   logic [CNT_W-1:0]        outstanding, fifo_cnt;
   logic [CNT_W:0]          credit_used;
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [63:0]             fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   fifo_last;
   logic [RD_LAT-1:0]       vld_p, last_p;
   logic                    cmd_acc, beat_acc, last_beat, rd_acc, push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      credit_used    = {1'b0, outstanding} + {1'b0, fifo_cnt};
      cmd_ready      = (state == IDLE);
      busy           = (state != IDLE);
      done           = (state == DONE);
      ordering_write = (state == WR) & s_wvalid;
      ordering_wdata = (state == WR) ? s_wdata : '0;
      s_wready       = (state == WR) & ordering_ready;
      // Beats in the latency line still own a FIFO slot, so they count against the credit.
      ordering_read  = (state == RD) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
      cmd_acc        = cmd_valid & cmd_ready;
      beat_acc       = (ordering_write | ordering_read) & ordering_ready;
      rd_acc         = ordering_read & ordering_ready;
      last_beat      = (word_cnt == ordering_num) && (node_cnt == NODE_LAST);
      push           = vld_p[RD_LAT-1];
      m_rvalid       = (fifo_cnt != '0);
      pop            = m_rvalid & m_rready;
      m_rdata        = m_rvalid ? fifo_data[rd_ptr] : '0;
      m_rlast        = m_rvalid & fifo_last[rd_ptr];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (cmd_acc) state_nxt = cmd_write ? WR : RD;
         WR:       if (beat_acc && last_beat) state_nxt = DONE;
         RD:       if (beat_acc && last_beat) state_nxt = RD_DRAIN;
         RD_DRAIN: if (pop && m_rlast) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         word_cnt     <= '0;
         node_cnt     <= '0;
         ordering_num <= '0;
         err          <= 1'b0;
         outstanding  <= '0;
         fifo_cnt     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         vld_p        <= '0;
         last_p       <= '0;
      end else begin
         state <= state_nxt;
         if (cmd_acc) begin
            ordering_num <= cmd_words;
            word_cnt     <= '0;
            node_cnt     <= '0;
            err          <= 1'b0;
         end else if (beat_acc) begin
            if (word_cnt == ordering_num) begin
               word_cnt <= '0;
               node_cnt <= node_cnt + 1'b1;
            end else begin
               word_cnt <= word_cnt + 1'b1;
            end
            if (last_beat && !exchange_shift_n) err <= 1'b1;
         end
         // Read latency line: p0 .. p(RD_LAT-1)
         vld_p[0]  <= rd_acc;
         last_p[0] <= rd_acc & last_beat;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p[i]  <= vld_p[i-1];
            last_p[i] <= last_p[i-1];
         end
         outstanding <= outstanding + CNT_W'(rd_acc) - CNT_W'(push);
         fifo_cnt    <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= ordering_rdata;
         fifo_last[wr_ptr] <= last_p[RD_LAT-1];
      end
   end
endmodule
